onchip_memory_loader: RTL and testbench
=======================================

Name: onchip_memory_loader

Overview:
- Avalon-MM master that sits directly upstream of the 8192x32 single-port on-chip RAM (s1).
- Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words and writes them to consecutive RAM addresses from 0.
- Reads the image back, computes a checksum and flags any mismatch.
- Loads the Nios boot image from a host link while the CPU is held in reset.

Parameters:
- ADDR_W, 13, RAM word-address width (RAM depth 2^ADDR_W words)
- DATA_W, 32, RAM word width; fixed at 32 (4 byte lanes)
- CNT_W, 15, byte-count width; max legal count is 2^ADDR_W*4

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begin load, sampled only in IDLE
- byte_count  input  CNT_W+1  image length in bytes, latched on start
- in_data  input  8  stream byte
- in_valid  input  1  stream byte valid
- in_ready  output  1  loader accepts byte this cycle
- mem_address  output  ADDR_W  RAM word address
- mem_byteenable  output  4  RAM byte lanes
- mem_chipselect  output  1  RAM select
- mem_write  output  1  RAM write strobe
- mem_writedata  output  32  RAM write data
- mem_readdata  input  32  RAM read data, valid one cycle after address/chipselect
- mem_clken  output  1  RAM clock enable; constant 1
- busy  output  1  high outside IDLE/DONE
- done  output  1  high in DONE until next start
- error  output  1  verify mismatch or illegal byte_count; valid with done
- checksum  output  32  modulo-2^32 sum of words written

Behaviour:
- Reset: all outputs 0 except mem_clken=1; FSM to IDLE; counters, checksum and pack register cleared. Reset mid-operation aborts immediately; RAM contents are undefined; no further writes.
- FSM states: IDLE, LOAD, FLUSH, VERIFY, VWAIT, DONE.
- IDLE: start -> latch byte_count.
  - byte_count==0 -> DONE, error=0, checksum=0, no RAM access.
  - byte_count > 2^ADDR_W*4 -> DONE, error=1, no RAM access.
  - Otherwise -> LOAD.
- DONE: start -> same as IDLE handling, and clears done/error/checksum first. start in any other state is ignored.
- LOAD: in_ready=1. A byte is accepted on in_valid&in_ready; byte i goes to lane i mod 4 (lane 0 = bits 7:0).
- Full word: the cycle after lane 3 is accepted, assert mem_chipselect=mem_write=1 for exactly one cycle with byteenable=4'b1111 and the word address. in_ready stays high during the write; the next word packs into a separate register, so there are no stalls.
- Last byte: when the accepted-byte count reaches byte_count -> FLUSH, in_ready=0.
- FLUSH: if the final word is partial, one write cycle with byteenable set to the filled lanes only (e.g. 1 byte -> 4'b0001, 3 bytes -> 4'b0111); unfilled lanes of writedata are 0. If the final word is full, its write is already issued. Then -> VERIFY at address 0.
- checksum: adds each written word (unfilled lanes counted as 0), modulo 2^32.
- VERIFY: chipselect=1, write=0, address=n; next state VWAIT.
- VWAIT: the address is still held; sample mem_readdata, mask unfilled lanes of the final word, add to the verify sum. Then n+1 -> VERIFY, or after the last word -> DONE.
- Verify read rate is one word per 2 cycles.
- DONE: done=1, busy=0; error=1 if verify sum != checksum.
- Address counter never wraps: max address is 2^ADDR_W-1 by construction of the byte_count check.
- in_valid while not in LOAD: ignored, in_ready=0.

Decomposition:
- Shared package: FSM state enum; constants RAM_WORDS=8192, LANES=4, MAX_BYTES=32768.
- One natural sub-module: onchip_memory_loader_packer (byte-to-word packer with lane counter, word-ready strobe and byteenable generation). The FSM, address counter and checksum stay in the top.
- The bench instantiates the real RAM model behind the master ports.

Test Plan:
- byte_count=8, bytes 01..08 continuous valid -> 2 writes: addr0=0x04030201, addr1=0x08070605, be=4'hF; checksum=0x0C0A0806; done=1, error=0.
- byte_count=5, bytes AA BB CC DD EE -> addr0=0xDDCCBBAA be=F; addr1 write be=4'b0001 data=0x000000EE; checksum=0xDDCCBC98; error=0.
- byte_count=0 -> done asserted within 2 cycles of start, no mem_chipselect pulse, checksum=0. byte_count=32769 -> done=1, error=1, no writes.
- byte_count=32768, random bytes with random in_valid gaps -> exactly 8192 full-word writes, last at addr 8191; no address wrap; error=0.
- Fault inject: bench corrupts RAM word 3 between FLUSH and VERIFY -> done=1, error=1.
- Assert reset mid-LOAD after 6 bytes, release, then start a new load with byte_count=4 -> all outputs 0 during reset, clean single write at addr0, done=1, error=0.

Source files
------------

// File: rtl/onchip_memory_loader_pkg.sv
// Shared constants, FSM state encoding and byte-lane helpers for the
// on-chip memory loader.
package onchip_memory_loader_pkg;

  localparam int RAM_WORDS = 8192;
  localparam int LANES     = 4;
  localparam int MAX_BYTES = RAM_WORDS * LANES;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_FLUSH  = 3'd2;
  localparam state_t ST_VERIFY = 3'd3;
  localparam state_t ST_VWAIT  = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Byte enables for a word holding n filled lanes; n==0 stands for a full word.
  function automatic logic [3:0] fill_be(input logic [1:0] n);
    case (n)
      2'd1:    fill_be = 4'b0001;
      2'd2:    fill_be = 4'b0011;
      2'd3:    fill_be = 4'b0111;
      default: fill_be = 4'b1111;
    endcase
  endfunction

  // Expand byte enables to a 32-bit data mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_to_mask[8*i +: 8] = {8{be[i]}};
  endfunction

endpackage

// File: rtl/onchip_memory_loader_if.sv
// Byte-stream input and Avalon-MM RAM master signals of the loader.
//   master modport: loader side (drives in_ready and the mem_* controls)
//   slave  modport: environment side (stream source plus RAM)
interface onchip_memory_loader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_clken;

  modport master (
    input  in_data, in_valid, mem_readdata,
    output in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output in_data, in_valid, mem_readdata,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/onchip_memory_loader_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : drop any partial word (new load)
//   accept     : a byte is taken this cycle
//   last       : the accepted byte is the final byte of the image
//   in_byte    : stream byte
//   word_wr    : one-cycle write strobe, the cycle after a word completes
//   word_data  : completed word, unfilled lanes zero
//   word_be    : filled lanes of word_data
module onchip_memory_loader_packer
  import onchip_memory_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              accept,
  input  logic              last,
  input  logic [7:0]        in_byte,
  output logic              word_wr,
  output logic [DATA_W-1:0] word_data,
  output logic [3:0]        word_be
);

  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = pack_q | (DATA_W'(in_byte) << {lane_q, 3'b000});
    lane_d = lane_q;
    pack_d = pack_q;
    data_d = data_q;
    be_d   = be_q;
    wr_d   = 1'b0;
    if (clr) begin
      lane_d = '0;
      pack_d = '0;
    end else if (accept) begin
      if (lane_q == 2'd3 || last) begin
        // Word leaves through its own register, so packing continues unstalled.
        wr_d   = 1'b1;
        data_d = merged;
        be_d   = fill_be(lane_q + 2'd1);
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      pack_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      wr_q   <= 1'b0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      data_q <= data_d;
      be_q   <= be_d;
      wr_q   <= wr_d;
    end
  end

  assign word_wr   = wr_q;
  assign word_data = data_q;
  assign word_be   = be_q;

endmodule

// File: rtl/onchip_memory_loader.sv
// Loads a byte-stream image into on-chip RAM from word 0, then reads it back
// and compares the read-back sum with the write checksum.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a load (honoured in IDLE/DONE only)
//   byte_count : image length in bytes, latched on start
//   bus        : byte stream in + Avalon-MM RAM master (master modport)
//   busy/done  : operation in progress / finished
//   error      : verify mismatch or illegal length, valid with done
//   checksum   : modulo-2^32 sum of words written
module onchip_memory_loader
  import onchip_memory_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W:0]       byte_count,
  onchip_memory_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [DATA_W-1:0]    checksum
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'((2 ** ADDR_W) * LANES);

  state_t            state_q, state_d;
  logic [CNT_W:0]    len_q, len_d;
  logic [CNT_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] vsum_q, vsum_d;
  logic              err_q, err_d;

  logic              accept, last, pk_clr, pk_wr, rd_phase;
  logic [DATA_W-1:0] pk_data, rd_masked;
  logic [3:0]        pk_be;
  logic [CNT_W:0]    cnt_inc, len_m1;
  logic [ADDR_W-1:0] last_word;

  assign accept    = bus.in_valid && (state_q == ST_LOAD);
  assign cnt_inc   = cnt_q + (CNT_W+1)'(1);
  assign last      = accept && (cnt_inc == len_q);
  assign len_m1    = len_q - (CNT_W+1)'(1);
  assign last_word = ADDR_W'(len_m1 >> 2);
  assign rd_phase  = (state_q == ST_VERIFY) || (state_q == ST_VWAIT);
  // Unfilled lanes of the final word hold stale RAM data and are not compared.
  assign rd_masked = bus.mem_readdata &
                     ((vaddr_q == last_word) ? be_to_mask(fill_be(len_q[1:0])) : '1);

  onchip_memory_loader_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (pk_clr),
    .accept    (accept),
    .last      (last),
    .in_byte   (bus.in_data),
    .word_wr   (pk_wr),
    .word_data (pk_data),
    .word_be   (pk_be)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    vaddr_d = vaddr_q;
    csum_d  = csum_q;
    vsum_d  = vsum_q;
    err_d   = err_q;
    pk_clr  = 1'b0;

    if (pk_wr) begin
      csum_d  = csum_q + pk_data;
      waddr_d = waddr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_d   = byte_count;
          cnt_d   = '0;
          waddr_d = '0;
          vaddr_d = '0;
          csum_d  = '0;
          vsum_d  = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
          if (byte_count == '0) begin
            state_d = ST_DONE;
          end else if (byte_count > MAX_CNT) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (last) state_d = ST_FLUSH;
        end
      end
      // The final (possibly partial) word is written by the packer in this cycle.
      ST_FLUSH:  state_d = ST_VERIFY;
      ST_VERIFY: state_d = ST_VWAIT;
      ST_VWAIT: begin
        vsum_d = vsum_q + rd_masked;
        if (vaddr_q == last_word) begin
          state_d = ST_DONE;
          err_d   = (vsum_d != csum_q);
        end else begin
          vaddr_d = vaddr_q + ADDR_W'(1);
          state_d = ST_VERIFY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      vaddr_q <= '0;
      csum_q  <= '0;
      vsum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      vaddr_q <= vaddr_d;
      csum_q  <= csum_d;
      vsum_q  <= vsum_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready       = (state_q == ST_LOAD);
  assign bus.mem_address    = rd_phase ? vaddr_q : waddr_q;
  assign bus.mem_chipselect = pk_wr || rd_phase;
  assign bus.mem_write      = pk_wr;
  assign bus.mem_byteenable = pk_wr ? pk_be : (rd_phase ? 4'hF : 4'h0);
  assign bus.mem_writedata  = pk_data;
  assign bus.mem_clken      = 1'b1;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign error    = err_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_onchip_memory_loader.sv
// Bench for onchip_memory_loader: RAM model behind the master port, byte
// source with random gaps, and a byte-level reference model of the image.
`timescale 1ns/1ps
module tb_onchip_memory_loader;
  import onchip_memory_loader_pkg::*;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W:0]    byte_count;
  logic              busy, done, error;
  logic [31:0]       checksum;

  always #5 clk = ~clk;

  onchip_memory_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  onchip_memory_loader #(.ADDR_W(ADDR_W), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_count (byte_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  // RAM model: 8192x32, byte-lane writes, registered read data.
  logic [31:0]       ram [RAM_WORDS];
  logic              corrupt_req;
  logic [ADDR_W-1:0] corrupt_addr;

  always @(posedge clk) begin
    if (corrupt_req) ram[corrupt_addr] <= ram[corrupt_addr] ^ 32'h0000_0100;
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write)
        for (int l = 0; l < 4; l++)
          if (bus.mem_byteenable[l]) ram[bus.mem_address][8*l +: 8] <= bus.mem_writedata[8*l +: 8];
      bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  // Bus monitor: cumulative counts, snapshots are taken per test.
  int                wr_total = 0, cs_total = 0, seq_err = 0, partial_total = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        last_be = '0;
  logic [31:0]       last_wdata = '0;

  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      cs_total <= cs_total + 1;
      if (bus.mem_write) begin
        wr_total <= wr_total + 1;
        if (bus.mem_address != '0 && bus.mem_address != last_addr + ADDR_W'(1)) seq_err <= seq_err + 1;
        if (bus.mem_byteenable != 4'hF) partial_total <= partial_total + 1;
        last_addr  <= bus.mem_address;
        last_be    <= bus.mem_byteenable;
        last_wdata <= bus.mem_writedata;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: image as a byte list.
  logic [7:0] img[$];

  function automatic logic [31:0] model_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < img.size(); i++) s += 32'(img[i]) << (8 * (i % 4));
    return s;
  endfunction

  function automatic int model_words();
    return (img.size() + 3) / 4;
  endfunction

  // Count RAM words whose written lanes differ from the image.
  function automatic int ram_diffs();
    int bad = 0;
    for (int k = 0; k < model_words(); k++) begin
      logic [31:0] w = '0, m = '0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < img.size()) begin
          w[8*j +: 8] = img[4*k + j];
          m[8*j +: 8] = 8'hFF;
        end
      if ((ram[k] & m) !== w) bad++;
    end
    return bad;
  endfunction

  task automatic fill_random(input int len);
    img.delete();
    for (int i = 0; i < len; i++) img.push_back(8'($urandom));
  endtask

  // Start a legal-length load, stream img with random gaps, wait for done.
  task automatic run_load(input int gap_pct, input bit corrupt);
    int idx = 0;
    int cyc = 0;
    int len = img.size();
    @(negedge clk);
    byte_count = (CNT_W+1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < len && cyc < len * 8 + 50) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = img[idx];
        if (bus.in_ready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (idx < len) check("stream_timeout", 32'(idx), 32'(len));
    if (corrupt) begin
      corrupt_addr = ADDR_W'(3);
      corrupt_req  = 1'b1;
      @(negedge clk);
      corrupt_req  = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 4 * len + 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int w0, c0, s0, p0;

  task automatic snap();
    w0 = wr_total; c0 = cs_total; s0 = seq_err; p0 = partial_total;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    corrupt_req = 1'b0; corrupt_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", {25'd0, busy, done, error, bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken}, 32'h1);
    check("rst_checksum", checksum, 32'h0);
    check("rst_addr_be", {15'd0, bus.mem_byteenable, bus.mem_address}, 32'h0);
    check("rst_wdata", bus.mem_writedata, 32'h0);
    reset = 1'b0;

    // Eight bytes 01..08.
    img.delete();
    for (int i = 1; i <= 8; i++) img.push_back(8'(i));
    snap();
    run_load(0, 1'b0);
    check("a_done", {31'd0, done}, 32'h1);
    check("a_error", {31'd0, error}, 32'h0);
    check("a_checksum", checksum, 32'h0C0A0806);
    check("a_ram0", ram[0], 32'h04030201);
    check("a_ram1", ram[1], 32'h08070605);
    check("a_writes", 32'(wr_total - w0), 32'd2);
    check("a_last_be", {28'd0, last_be}, 32'hF);

    // Five bytes, partial final word.
    img.delete();
    img.push_back(8'hAA); img.push_back(8'hBB); img.push_back(8'hCC);
    img.push_back(8'hDD); img.push_back(8'hEE);
    snap();
    run_load(0, 1'b0);
    check("b_ram0", ram[0], 32'hDDCCBBAA);
    check("b_last_be", {28'd0, last_be}, 32'h1);
    check("b_last_wdata", last_wdata, 32'h000000EE);
    check("b_last_addr", 32'(last_addr), 32'd1);
    check("b_checksum", checksum, 32'hDDCCBC98);
    check("b_error", {31'd0, done, error}, 32'h2);

    // Zero length, stream held valid outside LOAD.
    snap();
    bus.in_valid = 1'b1;
    @(negedge clk);
    byte_count = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!done) @(negedge clk);
    check("z_done", {31'd0, done}, 32'h1);
    check("z_checksum", checksum, 32'h0);
    check("z_error", {31'd0, error}, 32'h0);
    check("z_in_ready", {31'd0, bus.in_ready}, 32'h0);
    @(negedge clk);
    check("z_no_access", 32'(cs_total - c0), 32'd0);
    bus.in_valid = 1'b0;

    // Illegal length 32769.
    snap();
    @(negedge clk);
    byte_count = 16'd32769; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!done) @(negedge clk);
    check("i_done_err", {30'd0, done, error}, 32'h3);
    @(negedge clk);
    check("i_no_access", 32'(cs_total - c0), 32'd0);

    // Short random images.
    for (int t = 0; t < 3; t++) begin
      fill_random($urandom_range(1, 40));
      snap();
      run_load(30, 1'b0);
      check("r_done_err", {30'd0, done, error}, 32'h2);
      check("r_checksum", checksum, model_sum());
      check("r_writes", 32'(wr_total - w0), 32'(model_words()));
      check("r_ram", 32'(ram_diffs()), 32'd0);
      check("r_last_be", {28'd0, last_be}, {28'd0, fill_be(2'(img.size()))});
    end

    // Full RAM image with gaps.
    fill_random(MAX_BYTES);
    snap();
    run_load(15, 1'b0);
    check("f_done_err", {30'd0, done, error}, 32'h2);
    check("f_writes", 32'(wr_total - w0), 32'd8192);
    check("f_partial", 32'(partial_total - p0), 32'd0);
    check("f_last_addr", 32'(last_addr), 32'd8191);
    check("f_seq", 32'(seq_err - s0), 32'd0);
    check("f_checksum", checksum, model_sum());
    check("f_ram", 32'(ram_diffs()), 32'd0);

    // RAM word 3 corrupted before read-back.
    fill_random(32);
    run_load(10, 1'b1);
    check("c_done_err", {30'd0, done, error}, 32'h3);
    check("c_checksum", checksum, model_sum());

    // Reset in the middle of a load, then a clean four-byte load.
    fill_random(20);
    @(negedge clk);
    byte_count = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = img[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    snap();
    @(negedge clk);
    check("m_rst_flags", {25'd0, busy, done, error, bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken}, 32'h1);
    check("m_rst_checksum", checksum, 32'h0);
    check("m_rst_addr_be", {15'd0, bus.mem_byteenable, bus.mem_address}, 32'h0);
    @(negedge clk);
    check("m_rst_no_write", 32'(wr_total - w0), 32'd0);
    reset = 1'b0;
    fill_random(4);
    snap();
    run_load(20, 1'b0);
    check("m_writes", 32'(wr_total - w0), 32'd1);
    check("m_last_addr_be", {15'd0, last_be, last_addr}, {15'd0, 4'hF, 13'd0});
    check("m_ram0", ram[0], {img[3], img[2], img[1], img[0]});
    check("m_done_err", {30'd0, done, error}, 32'h2);
    check("m_checksum", checksum, model_sum());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
